ctrl_pipe_hazard: RTL

- Parametrised successor of the combinational control path (ruta_ctrl).
- Decodes opcode/funct in ID and carries the control bundles through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall) and taken branches/jumps (flush).
- Keeps saturating stall/flush event counters for debug.
- Sits between the IF/ID register and the datapath stage registers of the 5-stage MIPS core.

---
 rtl/ctrl_pipe_hazard.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: MIPS control decode, stage control pipeline, load-use stall, branch/jump flush and event counters
module ctrl_pipe_hazard #(
  parameter int OP_W  = 6,
  parameter int FN_W  = 6,
  parameter int RG_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic [FN_W-1:0]  funct,
  input  logic [RG_W-1:0]  rs,
  input  logic [RG_W-1:0]  rt,
  input  logic [RG_W-1:0]  rd,
  input  logic             zero_ex,
  output logic [1:0]       SEL_DIR,
  output logic             resetIF,
  output logic             pc_stall,
  output logic [4:0]       ctrl_EXE,
  output logic [2:0]       ctrl_MEM,
  output logic [1:0]       ctrl_WB,
  output logic [RG_W-1:0]  wb_dst,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [OP_W-1:0] OP_R    = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_J    = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'('h08);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'('h0A);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'('h2B);
  localparam logic [FN_W-1:0] FN_ADD  = FN_W'('h20);
  localparam logic [FN_W-1:0] FN_SUB  = FN_W'('h22);
  localparam logic [FN_W-1:0] FN_AND  = FN_W'('h24);
  localparam logic [FN_W-1:0] FN_OR   = FN_W'('h25);
  localparam logic [FN_W-1:0] FN_SLT  = FN_W'('h2A);
  logic [9:0]       w_bundle;
  logic             w_illegal;
  logic [RG_W-1:0]  w_dst;
  logic             w_reads_rt;
  logic             w_br;
  logic             w_jmp;
  logic             w_stall;
  logic             w_kill;
  logic [4:0]       r_ex_exe;
  logic [2:0]       r_ex_mem;
  logic [1:0]       r_ex_wb;
  logic [RG_W-1:0]  r_ex_dst;
  logic [RG_W-1:0]  r_ex_rt;
  logic [2:0]       r_mem_mem;
  logic [1:0]       r_mem_wb;
  logic [RG_W-1:0]  r_mem_dst;
  logic [1:0]       r_wb_wb;
  logic [RG_W-1:0]  r_wb_dst;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  // ID decode into {RegDst, ALUSrc, ALUOp[2:0], MemRead, MemWrite, Branch, RegWrite, MemToReg}
  always_comb begin
    w_bundle  = '0;
    w_illegal = 1'b0;
    case (opcode)
      OP_R:
        case (funct)
          FN_ADD:  w_bundle = 10'b10_000_000_10;
          FN_SUB:  w_bundle = 10'b10_001_000_10;
          FN_AND:  w_bundle = 10'b10_010_000_10;
          FN_OR:   w_bundle = 10'b10_011_000_10;
          FN_SLT:  w_bundle = 10'b10_100_000_10;
          default: w_illegal = 1'b1;
        endcase
      OP_ADDI: w_bundle = 10'b01_000_000_10;
      OP_SLTI: w_bundle = 10'b01_100_000_10;
      OP_LW:   w_bundle = 10'b01_000_100_11;
      OP_SW:   w_bundle = 10'b01_000_010_00;
      OP_BEQ:  w_bundle = 10'b00_001_001_00;
      OP_J:    w_bundle = '0;
      default: w_illegal = 1'b1;
    endcase
  end
  assign w_dst      = w_illegal ? '0 : w_bundle[9] ? rd : rt;
  assign w_reads_rt = opcode == OP_R || opcode == OP_SW || opcode == OP_BEQ;
  assign w_br       = r_ex_mem[0] && zero_ex;
  assign w_jmp      = !w_br && opcode == OP_J;
  assign w_stall    = !w_br && !w_jmp && r_ex_mem[2] && r_ex_rt != '0 &&
                      (r_ex_rt == rs || (w_reads_rt && r_ex_rt == rt));
  assign w_kill     = w_br || w_jmp || w_stall;
  assign SEL_DIR    = reset ? 2'b00 : w_br ? 2'b01 : w_jmp ? 2'b10 : 2'b00;
  assign resetIF    = reset || w_br || w_jmp;
  assign pc_stall   = !reset && w_stall;
  assign illegal    = w_illegal;
  assign ctrl_EXE   = r_ex_exe;
  assign ctrl_MEM   = r_mem_mem;
  assign ctrl_WB    = r_wb_wb;
  assign wb_dst     = r_wb_dst;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  // stage registers: ID/EX takes the decode or a bubble, later stages always advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_exe  <= '0;
      r_ex_mem  <= '0;
      r_ex_wb   <= '0;
      r_ex_dst  <= '0;
      r_ex_rt   <= '0;
      r_mem_mem <= '0;
      r_mem_wb  <= '0;
      r_mem_dst <= '0;
      r_wb_wb   <= '0;
      r_wb_dst  <= '0;
    end else begin
      {r_ex_exe, r_ex_mem, r_ex_wb} <= w_kill ? '0 : w_bundle;
      r_ex_dst  <= w_kill ? '0 : w_dst;
      r_ex_rt   <= w_kill ? '0 : rt;
      r_mem_mem <= r_ex_mem;
      r_mem_wb  <= r_ex_wb;
      r_mem_dst <= r_ex_dst;
      r_wb_wb   <= r_mem_wb;
      r_wb_dst  <= r_mem_dst;
    end
  end
  // saturating debug counters of stall and flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((w_br || w_jmp) && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule
